// File: rtl/serial_to_parallel_8_pkg.sv
// Shared defaults and output-side state encoding for the serial-to-parallel receiver.
package serial_to_parallel_8_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int IDX_W_DEF = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/serial_to_parallel_8_demux1to8.sv
// 1-to-WIDTH decoder: one-hot write enable for the assembly bit selected by sel,
// all zero when en is low.
module serial_to_parallel_8_demux1to8
  import serial_to_parallel_8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [IDX_W-1:0] sel,
  input  logic             en,
  output logic [WIDTH-1:0] y
);

  // One-hot decode of sel, gated by en
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/serial_to_parallel_8.sv
// Serial-to-parallel receiver: assembles WIDTH serial bits (LSB first) and
// offers completed words on a single-entry valid/ready output holding register.
// Output-side FSM states:
//   state | meaning
//   EMPTY | holding register has no unconsumed word
//   FULL  | holding register offers a word (out_valid = 1)
module serial_to_parallel_8
  import serial_to_parallel_8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             in_valid,
  input  logic             abort,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [IDX_W-1:0] bit_index,
  output logic             busy,
  output logic             overrun
);

  out_state_t       state_q, state_next;
  logic [WIDTH-1:0] asm_q, asm_next;
  logic [WIDTH-1:0] bit_we;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] out_q;
  logic             overrun_q;
  logic             accept, complete, transfer, load_out;

  // A bit presented alongside abort is deliberately ignored.
  assign accept   = in_valid & ~abort;
  assign complete = accept && (idx_q == IDX_W'(WIDTH - 1));
  assign transfer = (state_q == FULL) && out_ready;
  // A finished word only lands if the slot is free now or is being drained this edge.
  assign load_out = complete && ((state_q == EMPTY) || transfer);

  serial_to_parallel_8_demux1to8 #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_demux (
    .sel(idx_q),
    .en (accept),
    .y  (bit_we)
  );

  // Merge the incoming bit into the assembly word so the completing bit is
  // already included when the word is loaded into the holding register.
  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < WIDTH; k++) begin
      if (bit_we[k]) asm_next[k] = serial_in;
    end
  end

  // Assembly register and write index
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q <= '0;
      idx_q <= '0;
    end else if (abort) begin
      asm_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      asm_q <= asm_next;
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Output FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_next;
  end

  // Output FSM next-state logic
  always_comb begin
    state_next = state_q;
    unique case (state_q)
      EMPTY: if (complete) state_next = FULL;
      FULL:  if (transfer && !complete) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Holding register and sticky overrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (load_out) out_q <= asm_next;
      if (complete && !load_out) overrun_q <= 1'b1;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == FULL);
  assign bit_index = idx_q;
  assign busy      = (idx_q != '0);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel_8.sv
// Self-checking bench for serial_to_parallel_8 with a queue-based reference model.
module tb_serial_to_parallel_8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out;
  logic       out_valid;
  logic [2:0] bit_index;
  logic       busy;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;

  // reference model: bits received so far plus the single output slot
  bit   m_bits[$];
  logic [7:0] m_out = '0;
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;

  serial_to_parallel_8 dut (
    .clk      (clk),
    .reset    (reset),
    .serial_in(serial_in),
    .in_valid (in_valid),
    .abort    (abort),
    .out_ready(out_ready),
    .out      (out),
    .out_valid(out_valid),
    .bit_index(bit_index),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic cycle(input logic sin, input logic iv, input logic ab,
                       input logic rdy, input logic rst);
    int   word;
    bit   done;
    bit   xfer;
    serial_in = sin; in_valid = iv; abort = ab; out_ready = rdy; reset = rst;
    @(posedge clk);
    if (rst) begin
      m_bits.delete(); m_out = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      xfer = m_valid && rdy;
      done = 1'b0;
      word = 0;
      if (ab) m_bits.delete();
      else if (iv) begin
        m_bits.push_back(sin);
        if (m_bits.size() == 8) begin
          for (int k = 0; k < 8; k++) word += int'(m_bits[k]) * (2 ** k);
          m_bits.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!m_valid || xfer) begin m_out = 8'(word); m_valid = 1'b1; end
        else m_ovr = 1'b1;
      end else if (xfer) m_valid = 1'b0;
    end
    #1;
  endtask

  // Send a word LSB first; ready applies to all bit cycles except last_rdy on the 8th.
  task automatic send_word(input logic [7:0] w, input logic rdy, input logic last_rdy,
                           input int max_gap);
    for (int k = 0; k < 8; k++) begin
      if (max_gap > 0) begin
        int g = $urandom_range(0, max_gap);
        for (int j = 0; j < g; j++) cycle(1'($urandom), 1'b0, 1'b0, rdy, 1'b0);
      end
      cycle(w[k], 1'b1, 1'b0, (k == 7) ? last_rdy : rdy, 1'b0);
    end
  endtask

  task automatic test_reset;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({out, out_valid, bit_index, busy, overrun} !== {m_out, m_valid, 3'(m_bits.size()), 1'b0, m_ovr}) begin
      miscompares++;
      $display("FAIL reset: out=%h v=%b idx=%0d busy=%b ovr=%b, want all zero", out, out_valid, bit_index, busy, overrun);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic;
    send_word(8'h4D, 1'b1, 1'b1, 0);
    vectors++;
    if (out !== 8'h4D || out_valid !== 1'b1 || bit_index !== 3'd0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_word: out=%h v=%b idx=%0d ovr=%b, want 4d 1 0 0", out, out_valid, bit_index, overrun);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_gaps;
    logic [7:0] w = 8'h4D;
    for (int k = 0; k < 8; k++) begin
      int g = $urandom_range(0, 3);
      for (int j = 0; j < g; j++) begin
        cycle(1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (busy !== (k != 0) || bit_index !== 3'(k)) begin
          miscompares++;
          $display("FAIL gap_hold: busy=%b idx=%0d, want %b %0d", busy, bit_index, (k != 0), k);
        end
      end
      cycle(w[k], 1'b1, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (busy !== (k != 7)) begin
        miscompares++;
        $display("FAIL gap_busy: bit %0d busy=%b, want %b", k, busy, (k != 7));
      end
    end
    vectors++;
    if (out !== 8'h4D || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_word: out=%h v=%b, want 4d 1", out, out_valid);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun;
    send_word(8'hA5, 1'b0, 1'b0, 0);
    send_word(8'h3C, 1'b0, 1'b0, 2);
    vectors++;
    if (out !== 8'hA5 || out_valid !== 1'b1 || overrun !== 1'b1 || bit_index !== 3'd0) begin
      miscompares++;
      $display("FAIL overrun_hold: out=%h v=%b ovr=%b idx=%0d, want a5 1 1 0", out, out_valid, overrun, bit_index);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_sticky: v=%b ovr=%b, want 0 1", out_valid, overrun);
    end
  endtask

  task automatic test_back_to_back;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h11, 1'b0, 1'b0, 0);
    send_word(8'h22, 1'b0, 1'b1, 0);
    vectors++;
    if (out !== 8'h22 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back: out=%h v=%b ovr=%b, want 22 1 0", out, out_valid, overrun);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_abort;
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (bit_index !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idx: idx=%0d busy=%b, want 0 0", bit_index, busy);
    end
    send_word(8'hF0, 1'b1, 1'b1, 0);
    vectors++;
    if (out !== 8'hF0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_word: out=%h v=%b, want f0 1", out, out_valid);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    send_word(8'h5A, 1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bit_index !== 3'd4 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL premid: idx=%0d v=%b, want 4 1", bit_index, out_valid);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({out, out_valid, bit_index, busy, overrun} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_mid: out=%h v=%b idx=%0d busy=%b ovr=%b, want all zero", out, out_valid, bit_index, busy, overrun);
    end
    send_word(8'h81, 1'b1, 1'b1, 0);
    vectors++;
    if (out !== 8'h81 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_word: out=%h v=%b, want 81 1", out, out_valid);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 150) == 0));
      vectors++;
      if (out !== m_out || out_valid !== m_valid || bit_index !== 3'(m_bits.size()) ||
          busy !== (m_bits.size() != 0) || overrun !== m_ovr) begin
        miscompares++;
        $display("FAIL random[%0d]: out=%h v=%b idx=%0d busy=%b ovr=%b, want %h %b %0d %b %b",
                 n, out, out_valid, bit_index, busy, overrun,
                 m_out, m_valid, m_bits.size(), (m_bits.size() != 0), m_ovr);
      end
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_basic;
    test_gaps;
    test_overrun;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
